vga_timing: RTL and testbench

//   Raster timing generator for the 800x600@60Hz display path. Runs on clk_40m (one pixel per clock).

---
 rtl/vga_timing.sv | 120 ++++++++++++
 tb/tb_vga_timing.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: free-running hc/vc counters plus registered blanking, sync,
// line/frame strobes and a frame counter, all aligned to the counter values they describe.
module vga_timing #(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic        clk_40m,
    input  logic        reset,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        vidon,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

    // 12-bit bounds so an end-of-range equal to 2048 does not truncate to zero
    localparam logic [11:0] H_VIS_B   = 12'(H_VIS);
    localparam logic [11:0] HS_BEGIN  = 12'(H_VIS + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_VIS + H_FP + H_SYNC);
    localparam logic [11:0] V_VIS_B   = 12'(V_VIS);
    localparam logic [11:0] VS_BEGIN  = 12'(V_VIS + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_VIS + V_FP + V_SYNC);

    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic        vidon_q, vidon_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        first_frame_q, first_frame_d;

    logic [11:0] hc_x;
    logic [11:0] vc_x;

    always_comb begin
        hc_d = hc_q + 11'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 11'd0;
            vc_d = (vc_q == V_LAST) ? 11'd0 : vc_q + 11'd1;
        end
    end

    // Flags decode the next count so they land in the same cycle as the counter value.
    always_comb begin
        hc_x          = {1'b0, hc_d};
        vc_x          = {1'b0, vc_d};
        vidon_d       = (hc_x < H_VIS_B) && (vc_x < V_VIS_B);
        hsync_d       = ((hc_x >= HS_BEGIN) && (hc_x < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d       = ((vc_x >= VS_BEGIN) && (vc_x < VS_END)) ? VS_POL : ~VS_POL;
        line_start_d  = (hc_d == 11'd0);
        frame_start_d = (hc_d == 11'd0) && (vc_d == 11'd0);
        frame_cnt_d   = frame_cnt_q;
        first_frame_d = first_frame_q;
        if (frame_start_d) begin
            first_frame_d = 1'b0;
            if (!first_frame_q) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Reset parks the raster on the last blanked pixel so release starts a clean frame.
    always_ff @(posedge clk_40m) begin
        if (reset) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            vidon_q       <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            first_frame_q <= 1'b1;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            vidon_q       <= vidon_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            first_frame_q <= first_frame_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign vidon       = vidon_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size and reduced-size instances, per-cycle scoreboard plus
// directed hand-computed checks on sync widths, wraps, resets and frame counting.
module tb_vga_timing;

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        vidon;
        logic        hsync;
        logic        vsync;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    typedef struct {
        int hvis, hfp, hsw, hbp;
        int vvis, vfp, vsw, vbp;
        bit hpol, vpol;
    } prm_t;

    localparam prm_t PA = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
    localparam prm_t PB = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b1};

    logic clk_40m = 1'b0;
    always #5 clk_40m = ~clk_40m;

    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [10:0] a_hc, a_vc, b_hc, b_vc;
    logic        a_vidon, a_hsync, a_vsync, a_ls, a_fs;
    logic        b_vidon, b_hsync, b_vsync, b_ls, b_fs;
    logic [7:0]  a_fc, b_fc;

    int n_vec = 0;
    int n_bad = 0;
    int n_print = 0;
    exp_t qa[$];
    exp_t qb[$];

    vga_timing dut_a (
        .clk_40m(clk_40m), .reset(rst_a), .hc(a_hc), .vc(a_vc), .vidon(a_vidon),
        .hsync(a_hsync), .vsync(a_vsync), .line_start(a_ls), .frame_start(a_fs),
        .frame_cnt(a_fc)
    );

    vga_timing #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1)
    ) dut_b (
        .clk_40m(clk_40m), .reset(rst_b), .hc(b_hc), .vc(b_vc), .vidon(b_vidon),
        .hsync(b_hsync), .vsync(b_vsync), .line_start(b_ls), .frame_start(b_fs),
        .frame_cnt(b_fc)
    );

    function automatic exp_t decode(prm_t p, int h, int v, logic [7:0] fc);
        exp_t e;
        e.hc    = 11'(h);
        e.vc    = 11'(v);
        e.vidon = (h < p.hvis) && (v < p.vvis);
        e.hsync = ((h >= p.hvis + p.hfp) && (h < p.hvis + p.hfp + p.hsw)) ? p.hpol : !p.hpol;
        e.vsync = ((v >= p.vvis + p.vfp) && (v < p.vvis + p.vfp + p.vsw)) ? p.vpol : !p.vpol;
        e.ls    = (h == 0);
        e.fs    = (h == 0) && (v == 0);
        e.fc    = fc;
        return e;
    endfunction

    task automatic model_step(input prm_t p, input logic rst, inout int h, inout int v,
                              inout logic [7:0] fc, inout bit first, inout bit live);
        int ht, vt;
        ht = p.hvis + p.hfp + p.hsw + p.hbp;
        vt = p.vvis + p.vfp + p.vsw + p.vbp;
        if (rst) begin
            h = ht - 1; v = vt - 1; fc = 8'd0; first = 1'b1; live = 1'b1;
        end else if (live) begin
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            if (h == 0 && v == 0) begin
                if (first) first = 1'b0;
                else fc = fc + 8'd1;
            end
        end
    endtask

    initial begin : model_a
        int h, v; logic [7:0] fc; bit first, live;
        h = 0; v = 0; fc = 8'd0; first = 1'b1; live = 1'b0;
        forever begin
            @(posedge clk_40m);
            model_step(PA, rst_a, h, v, fc, first, live);
            if (live) qa.push_back(decode(PA, h, v, fc));
        end
    end

    initial begin : model_b
        int h, v; logic [7:0] fc; bit first, live;
        h = 0; v = 0; fc = 8'd0; first = 1'b1; live = 1'b0;
        forever begin
            @(posedge clk_40m);
            model_step(PB, rst_b, h, v, fc, first, live);
            if (live) qb.push_back(decode(PB, h, v, fc));
        end
    end

    task automatic compare(input string nm, input exp_t e, input exp_t g);
        n_vec++;
        if (g !== e) begin
            n_bad++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s t=%0t got hc=%0d vc=%0d vid=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, expected hc=%0d vc=%0d vid=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                         nm, $time, g.hc, g.vc, g.vidon, g.hsync, g.vsync, g.ls, g.fs, g.fc,
                         e.hc, e.vc, e.vidon, e.hsync, e.vsync, e.ls, e.fs, e.fc);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(negedge clk_40m);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                g = {a_hc, a_vc, a_vidon, a_hsync, a_vsync, a_ls, a_fs, a_fc};
                compare("scoreboard_a", e, g);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                g = {b_hc, b_vc, b_vidon, b_hsync, b_vsync, b_ls, b_fs, b_fc};
                compare("scoreboard_b", e, g);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic stim_a();
        int vid_cnt, hs_cnt, hs_first, hs_last, ls_cnt;
        bit found;
        repeat (3) @(negedge clk_40m);
        chk("a_rst_hc", a_hc, 1055);
        chk("a_rst_vc", a_vc, 627);
        chk("a_rst_vidon", a_vidon, 0);
        chk("a_rst_hsync", a_hsync, 0);
        chk("a_rst_vsync", a_vsync, 0);
        chk("a_rst_fs", a_fs, 0);
        chk("a_rst_fc", a_fc, 0);
        rst_a = 1'b0;
        @(negedge clk_40m);
        chk("a_first_hc", a_hc, 0);
        chk("a_first_vc", a_vc, 0);
        chk("a_first_vidon", a_vidon, 1);
        chk("a_first_ls", a_ls, 1);
        chk("a_first_fs", a_fs, 1);
        chk("a_first_fc", a_fc, 0);
        vid_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
        for (int i = 0; i < 1056; i++) begin
            if (i > 0) @(negedge clk_40m);
            if (a_vidon) vid_cnt++;
            if (a_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(a_hc);
                hs_last = int'(a_hc);
            end
            if (a_ls) ls_cnt++;
        end
        chk("a_line_vidon_cnt", vid_cnt, 800);
        chk("a_line_hsync_cnt", hs_cnt, 128);
        chk("a_line_hsync_first", hs_first, 840);
        chk("a_line_hsync_last", hs_last, 967);
        chk("a_line_ls_cnt", ls_cnt, 1);
        @(negedge clk_40m);
        chk("a_line2_hc", a_hc, 0);
        chk("a_line2_vc", a_vc, 1);
        chk("a_line2_ls", a_ls, 1);
        chk("a_line2_fs", a_fs, 0);
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk_40m);
            found = (a_hc == 11'd500) && (a_vc == 11'd2);
        end
        chk("a_reach_500_2", found, 1);
        rst_a = 1'b1;
        @(negedge clk_40m);
        chk("a_midrst_hc", a_hc, 1055);
        chk("a_midrst_vc", a_vc, 627);
        chk("a_midrst_vidon", a_vidon, 0);
        chk("a_midrst_hsync", a_hsync, 0);
        chk("a_midrst_ls", a_ls, 0);
        chk("a_midrst_fs", a_fs, 0);
        rst_a = 1'b0;
        @(negedge clk_40m);
        chk("a_restart_hc", a_hc, 0);
        chk("a_restart_vc", a_vc, 0);
        chk("a_restart_fs", a_fs, 1);
        chk("a_restart_fc", a_fc, 0);
    endtask

    task automatic stim_b();
        int gap, vs_cnt, vs_hc, vs_vc, hs_low, hs_bad, vid_cnt;
        bit found;
        repeat (3) @(negedge clk_40m);
        chk("b_rst_hc", b_hc, 7);
        chk("b_rst_vc", b_vc, 5);
        chk("b_rst_hsync", b_hsync, 1);
        chk("b_rst_vsync", b_vsync, 0);
        rst_b = 1'b0;
        @(negedge clk_40m);
        chk("b_first_fs", b_fs, 1);
        chk("b_first_fc", b_fc, 0);
        for (int k = 1; k <= 256; k++) begin
            gap = 0;
            do begin
                @(negedge clk_40m);
                gap++;
            end while (!b_fs && gap < 100);
            chk("b_frame_period", gap, 48);
            chk("b_frame_cnt", b_fc, k % 256);
        end
        vs_cnt = 0; vs_hc = -1; vs_vc = -1; hs_low = 0; hs_bad = 0; vid_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (i > 0) @(negedge clk_40m);
            if (b_vsync) begin
                if (vs_cnt == 0) begin vs_hc = int'(b_hc); vs_vc = int'(b_vc); end
                vs_cnt++;
            end
            if (!b_hsync) begin
                hs_low++;
                if (b_hc != 11'd5 && b_hc != 11'd6) hs_bad++;
            end
            if (b_vidon) vid_cnt++;
        end
        chk("b_vsync_cnt", vs_cnt, 8);
        chk("b_vsync_start_hc", vs_hc, 0);
        chk("b_vsync_start_vc", vs_vc, 4);
        chk("b_hsync_low_cnt", hs_low, 12);
        chk("b_hsync_low_outside", hs_bad, 0);
        chk("b_vidon_cnt", vid_cnt, 12);
        @(negedge clk_40m);
        chk("b_wrap_hc", b_hc, 0);
        chk("b_wrap_vc", b_vc, 0);
        chk("b_wrap_fs", b_fs, 1);
        chk("b_wrap_fc", b_fc, 1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_40m);
            found = (b_hc == 11'd7) && (b_vc == 11'd1);
        end
        chk("b_reach_7_1", found, 1);
        @(negedge clk_40m);
        chk("b_linewrap_hc", b_hc, 0);
        chk("b_linewrap_vc", b_vc, 2);
        chk("b_linewrap_ls", b_ls, 1);
        chk("b_linewrap_fs", b_fs, 0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_40m);
            found = (b_hc == 11'd2) && (b_vc == 11'd2);
        end
        chk("b_reach_2_2", found, 1);
        rst_b = 1'b1;
        @(negedge clk_40m);
        chk("b_midrst_hc", b_hc, 7);
        chk("b_midrst_vc", b_vc, 5);
        chk("b_midrst_vidon", b_vidon, 0);
        chk("b_midrst_hsync", b_hsync, 1);
        chk("b_midrst_fc", b_fc, 0);
        rst_b = 1'b0;
        @(negedge clk_40m);
        chk("b_restart_fs", b_fs, 1);
        chk("b_restart_fc", b_fc, 0);
        gap = 0;
        do begin
            @(negedge clk_40m);
            gap++;
        end while (!b_fs && gap < 100);
        chk("b_restart_period", gap, 48);
        chk("b_restart_fc_next", b_fc, 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        fork
            stim_a();
            stim_b();
        join
        @(negedge clk_40m);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
